// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron sequencer: sizes, controller state
// encoding and the ReLU/saturation applied to every neuron sum.
package perceptron_pkg;

  localparam int N_IN  = 8;   // binary inputs per neuron (rx byte bits, LSB first)
  localparam int N_OUT = 15;  // neurons, one response byte each
  localparam int W_W   = 8;   // signed weight / bias width
  localparam int ACC_W = 12;  // signed accumulator width
  localparam int AW    = 8;   // weight memory address width

  // Counter widths derived from the sizes above
  localparam int KW  = $clog2(N_IN + 1);  // fetch index 0..N_IN (N_IN is the bias)
  localparam int XIW = $clog2(N_IN);      // index into the latched input bits
  localparam int NW  = $clog2(N_OUT);     // neuron counter

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    LAST,
    SEND,
    NEXT
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(255);

  // Negative or zero sums clamp to 0, sums of 255 and above clamp to 255
  function automatic logic [7:0] relu_sat(input logic signed [ACC_W-1:0] acc);
    logic [7:0] r;
    if (acc <= ACC_ZERO) begin
      r = 8'h00;
    end else if (acc >= SAT_HI) begin
      r = 8'hFF;
    end else begin
      r = acc[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Multiply-free accumulate datapath: one fetch-tracking pipe stage that carries
// the valid/enable of each weight read, followed by the signed accumulator.
// The saturated ReLU of the running sum is presented combinationally.
module perceptron_mac
  import perceptron_pkg::*;
(
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  clear,
  input  logic                  vld_p0,
  input  logic                  en_p0,
  input  logic signed [W_W-1:0] w_data,
  output logic [7:0]            res
);

  logic                    vld_p1;
  logic                    en_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic signed [ACC_W-1:0] w_ext;

  // Sign extension of the weight arriving one cycle after its address
  assign w_ext = ACC_W'(w_data);

  // ---- stage p0 -> p1: follow each weight read until its data returns ----
  // Delay fetch valid/enable by the memory read latency
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      vld_p1 <= 1'b0;
      en_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      en_p1  <= en_p0;
    end
  end

  // ---- stage p1 -> p2: accumulate the returned weight when its bit is set ----
  // Clear at the start of each neuron, otherwise add enabled weights
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      acc_p2 <= '0;
    end else if (clear) begin
      acc_p2 <= '0;
    end else if (vld_p1 && en_p1) begin
      acc_p2 <= acc_p2 + w_ext;
    end
  end

  assign res = relu_sat(acc_p2);

endmodule

// File: rtl/perceptron_ctrl.sv
// Perceptron sequencer between UART rx and tx. One host byte supplies the
// binary inputs; each neuron sums its bias and the weights of the set bits
// from a synchronous weight memory, and the ReLU-saturated sum is sent as one
// byte. The next neuron computes while the previous byte shifts out.
module perceptron_ctrl
  import perceptron_pkg::*;
(
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [AW-1:0]         w_addr,
  input  logic signed [W_W-1:0] w_data,
  output logic                  tx_load,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  rx_drop
);

  localparam logic [KW-1:0] K_LAST = KW'(N_IN);
  localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);
  localparam logic [AW-1:0] STRIDE = AW'(N_IN + 1);

  state_t           state;
  logic [N_IN-1:0]  x;
  logic [NW-1:0]    n;
  logic [KW-1:0]    k;
  logic [AW-1:0]    base;
  logic             clear;
  logic             vld_p0;
  logic             en_p0;
  logic [7:0]       mac_res;

  // The bias slot is always accumulated; weight slots follow their input bit
  assign clear   = (state == CLEAR);
  assign vld_p0  = (state == FETCH);
  assign en_p0   = (k == K_LAST) || x[k[XIW-1:0]];

  // Bytes arriving while a frame is in flight are discarded and flagged
  assign rx_drop = rx_valid && busy;

  perceptron_mac u_mac (
    .clk    (clk),
    .nRst   (nRst),
    .clear  (clear),
    .vld_p0 (vld_p0),
    .en_p0  (en_p0),
    .w_data (w_data),
    .res    (mac_res)
  );

  // Controller FSM: frame start, per-neuron fetch sequencing and tx handshake
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      x       <= '0;
      n       <= '0;
      k       <= '0;
      base    <= '0;
      w_addr  <= '0;
      tx_load <= 1'b0;
      tx_data <= '0;
      busy    <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            x     <= rx_data[N_IN-1:0];
            n     <= '0;
            base  <= '0;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          // First address of this neuron is issued on entry to FETCH
          k      <= '0;
          w_addr <= base;
          state  <= FETCH;
        end
        FETCH: begin
          if (k == K_LAST) begin
            state <= LAST;
          end else begin
            k      <= k + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end
        LAST: begin
          // The bias read returns now; its add lands at the end of this cycle
          state <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_load <= 1'b1;
            tx_data <= mac_res;
            state   <= NEXT;
          end
        end
        NEXT: begin
          if (n == N_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            n     <= n + 1'b1;
            base  <= base + STRIDE;
            state <= CLEAR;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Directed bench for perceptron_ctrl with a synchronous weight memory, a UART
// tx busy model and a frame-level reference model of the neuron outputs.
module tb_perceptron_ctrl;

  localparam int NI = 8;
  localparam int NO = 15;
  localparam int STR = NI + 1;

  logic              clk = 1'b0;
  logic              nRst = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [7:0]        w_addr;
  logic signed [7:0] w_data;
  logic              tx_load;
  logic [7:0]        tx_data;
  logic              tx_busy = 1'b0;
  logic              busy;
  logic              rx_drop;

  logic signed [7:0] mem [256];

  int checks = 0;
  int errors = 0;
  int busy_len = 3;
  int bcnt = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         addr_q[$];
  logic       busy_m = 1'b0;
  int         loads = 0;
  int         frames_done = 0;
  int         total_loads = 0;
  int         drops_seen = 0;

  perceptron_ctrl dut (
    .clk      (clk),
    .nRst     (nRst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .rx_drop  (rx_drop)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: data appears the cycle after the address
  always @(posedge clk) w_data <= mem[w_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected byte for neuron nn given input byte xb, from the memory contents
  function automatic logic [7:0] model_byte(input int nn, input logic [7:0] xb);
    int s;
    s = mem[nn*STR + NI];
    for (int i = 0; i < NI; i++) if (xb[i]) s += mem[nn*STR + i];
    if (s <= 0) return 8'h00;
    if (s >= 255) return 8'hFF;
    return s[7:0];
  endfunction

  // UART tx model: busy the cycle after a load, for busy_len cycles
  initial begin
    forever begin
      @(negedge clk);
      if (!nRst) begin
        tx_busy = 1'b0;
        bcnt = 0;
      end else if (tx_load) begin
        tx_busy = 1'b1;
        bcnt = busy_len;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) tx_busy = 1'b0;
      end
    end
  end

  // Compare process: checks busy, rx_drop and every loaded byte against the model
  initial begin
    logic nxt;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        exp_q.delete();
        busy_m = 1'b0;
        loads = 0;
      end else begin
        nxt = busy_m;
        chk("busy", busy, busy_m);
        chk("rx_drop", rx_drop, rx_valid && busy_m);
        if (rx_drop) drops_seen++;
        if (busy_m && (addr_q.size() == 0 || addr_q[$] != int'(w_addr)))
          addr_q.push_back(int'(w_addr));
        if (tx_load) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_load_unexpected actual=1 required=0 data=%0h", tx_data);
          end else begin
            chk("tx_data", tx_data, exp_q.pop_front());
          end
          got_q.push_back(tx_data);
          total_loads++;
          loads++;
          if (loads == NO) begin
            loads = 0;
            nxt = 1'b0;
            frames_done++;
          end
        end
        if (rx_valid && !busy_m) begin
          nxt = 1'b1;
          addr_q.delete();
          for (int nn = 0; nn < NO; nn++) exp_q.push_back(model_byte(nn, rx_data));
        end
        busy_m = nxt;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input logic [7:0] xb);
    got_q.delete();
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = xb;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt, input int budget, input string name);
    int c;
    c = 0;
    while (frames_done == base_cnt && c < budget) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (frames_done == base_cnt) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, frames_done, base_cnt + 1);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Weight address trace: n*9+0..8 for every neuron, in order
  task automatic check_addr(input string name);
    if (addr_q.size() > 0 && addr_q[0] != 0) void'(addr_q.pop_front());
    chk({name, "_addr_len"}, addr_q.size(), NO*STR);
    for (int i = 0; i < NO*STR && i < addr_q.size(); i++)
      chk({name, "_addr"}, addr_q[i], i);
  endtask

  task automatic run_frame(input logic [7:0] xb, input int budget, input string name);
    int fd;
    fd = frames_done;
    start_frame(xb);
    wait_done(fd, budget, name);
    chk({name, "_len"}, got_q.size(), NO);
    check_addr(name);
  endtask

  initial begin
    int fd;
    int c;
    int d0;
    int l0;
    for (int a = 0; a < 256; a++) mem[a] = 8'sd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w_addr", w_addr, 0);
    chk("rst_tx_load", tx_load, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_drop", rx_drop, 0);
    nRst = 1'b1;
    repeat (2) @(posedge clk);

    // All weights +1, biases 0, six set bits -> 6 per neuron
    for (int a = 0; a < NO*STR; a++) mem[a] = (a % STR == NI) ? 8'sd0 : 8'sd1;
    run_frame(8'hFA, 1000, "ones");
    chk("ones_b0", got_q[0], 8'h06);
    chk("ones_b14", got_q[14], 8'h06);

    // Weights 0, bias n*8 except neuron 3 bias -5 -> clamps to zero
    for (int a = 0; a < NO*STR; a++) mem[a] = 8'sd0;
    for (int nn = 0; nn < NO; nn++) mem[nn*STR + NI] = 8'(nn*8);
    mem[3*STR + NI] = -8'sd5;
    run_frame(8'h3C, 1000, "bias");
    chk("bias_b3", got_q[3], 8'h00);
    chk("bias_b7", got_q[7], 8'h38);
    chk("bias_b14", got_q[14], 8'h70);

    // Everything +127 with all bits set -> upper saturation
    for (int a = 0; a < NO*STR; a++) mem[a] = 8'sd127;
    run_frame(8'hFF, 1000, "sat");
    chk("sat_b0", got_q[0], 8'hFF);
    chk("sat_b14", got_q[14], 8'hFF);

    // Mixed signed weights; rx_valid mid-frame and on the return-to-idle cycle
    for (int a = 0; a < 256; a++) mem[a] = 8'(a*37 - 60);
    fd = frames_done;
    d0 = drops_seen;
    start_frame(8'h5C);
    repeat (20) @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'h81;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    c = 0;
    while (!(tx_load && loads == NO-1) && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("last_load_seen", tx_load, 1'b1);
    rx_valid = 1'b1;
    rx_data  = 8'h42;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    wait_done(fd, 1000, "mixed");
    chk("mixed_len", got_q.size(), NO);
    chk("mixed_b0", got_q[0], 8'h27);
    chk("mixed_drops", drops_seen - d0, 2);
    chk("mixed_idle", busy, 1'b0);
    check_addr("mixed");

    // Long tx stall: each byte waits, no reissue, order preserved
    busy_len = 2000;
    l0 = total_loads;
    run_frame(8'hA3, 40000, "stall");
    chk("stall_loads", total_loads - l0, NO);
    busy_len = 3;
    repeat (5) @(posedge clk);

    // Reset in the middle of FETCH abandons the frame
    start_frame(8'hFF);
    repeat (4) @(posedge clk);
    #2;
    nRst = 1'b0;
    #1;
    chk("mid_rst_w_addr", w_addr, 0);
    chk("mid_rst_tx_load", tx_load, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_drop", rx_drop, 0);
    #100;
    @(posedge clk); #2;
    nRst = 1'b1;
    l0 = total_loads;
    repeat (60) @(posedge clk);
    #1;
    chk("post_rst_loads", total_loads - l0, 0);
    chk("post_rst_busy", busy, 0);

    // Recovery after reset
    run_frame(8'h01, 1000, "recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
